// File: rtl/bus_datapath_pkg.sv
// Shared constants for the transfer bus: default width, address map and ALU opcodes.
// The control unit imports the same package, so both ends agree on the encoding.
package bus_datapath_pkg;

  localparam int DEF_DATA_W = 9;

  localparam logic [3:0] ADDR_DIN = 4'd8;
  localparam logic [3:0] ADDR_A   = 4'd9;
  localparam logic [3:0] ADDR_G   = 4'd10;
  localparam logic [3:0] ADDR_IR  = 4'd11;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

endpackage

// File: rtl/bus_datapath_alu.sv
// Combinational ALU: result = f(a, b) and carry, where b is the bus latch.
// For sub, carry reports a borrow. Logic ops, slt and pass report carry = 0.
module bus_alu
  import bus_datapath_pkg::*;
#(
  parameter int W = DEF_DATA_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [2:0]   op,
  output logic [W-1:0] result,
  output logic         carry
);

  logic [W:0] wide;

  always_comb begin
    wide   = '0;
    result = b;
    carry  = 1'b0;
    case (op)
      OP_ADD: begin
        wide   = {1'b0, a} + {1'b0, b};
        result = wide[W-1:0];
        carry  = wide[W];
      end
      OP_SUB: begin
        // The top bit of the widened difference is set exactly when a < b.
        wide   = {1'b0, a} - {1'b0, b};
        result = wide[W-1:0];
        carry  = wide[W];
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_SLT: result = (a < b) ? W'(1) : '0;
      default: result = b;
    endcase
  end

endmodule

// File: rtl/bus_datapath.sv
// Responder side of the transfer bus. It holds R0-R7, A, G, IR and the bus latch,
// and decodes the per-cycle command {addr, val, aluen, opcode}.
module bus_datapath
  import bus_datapath_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] din,
  input  logic [3:0]        addr,
  input  logic              val,
  input  logic              aluen,
  input  logic [2:0]        opcode,
  output logic [8:0]        ir,
  output logic [DATA_W-1:0] bus_q,
  output logic              zero,
  output logic              carry
);

  logic [DATA_W-1:0] r [8];
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] g_q;
  logic [DATA_W-1:0] src;
  logic [DATA_W-1:0] alu_res;
  logic              alu_carry;

  bus_alu #(.W(DATA_W)) u_alu (
    .a      (a_q),
    .b      (bus_q),
    .op     (opcode),
    .result (alu_res),
    .carry  (alu_carry)
  );

  // Reserved addresses 12-15 read as zero.
  always_comb begin
    src = '0;
    if (!addr[3]) begin
      src = r[addr[2:0]];
    end else begin
      case (addr)
        ADDR_DIN: src = din;
        ADDR_A:   src = a_q;
        ADDR_G:   src = g_q;
        ADDR_IR:  src[8:0] = ir;
        default:  src = '0;
      endcase
    end
  end

  // Every command is repeatable without changing the result, so each one is
  // simply applied on every edge for as long as the control unit holds it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) r[i] <= '0;
      a_q   <= '0;
      g_q   <= '0;
      ir    <= '0;
      bus_q <= '0;
      zero  <= 1'b0;
      carry <= 1'b0;
    end else if (aluen) begin
      g_q   <= alu_res;
      carry <= alu_carry;
      zero  <= (alu_res == '0);
    end else if (val) begin
      bus_q <= src;
    end else begin
      if (!addr[3]) begin
        r[addr[2:0]] <= bus_q;
      end else begin
        case (addr)
          ADDR_A:  a_q <= bus_q;
          ADDR_G:  g_q <= bus_q;
          ADDR_IR: ir  <= bus_q[8:0];
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bus_datapath.sv
// Directed, table-driven bench for bus_datapath. It covers mid-cycle reset, fetch,
// load/move, every ALU op, ALU override of val/addr, and ignored writes.
module tb_bus_datapath;
  import bus_datapath_pkg::*;

  localparam int W = 9;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] din;
  logic [3:0]   addr;
  logic         val;
  logic         aluen;
  logic [2:0]   opcode;
  logic [8:0]   ir;
  logic [W-1:0] bus_q;
  logic         zero;
  logic         carry;

  int n_checks = 0;
  int n_fail   = 0;

  bus_datapath #(.DATA_W(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .din    (din),
    .addr   (addr),
    .val    (val),
    .aluen  (aluen),
    .opcode (opcode),
    .ir     (ir),
    .bus_q  (bus_q),
    .zero   (zero),
    .carry  (carry)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (!reset && !aluen)
      assert (!$isunknown(val)) else $error("val unknown while aluen=0");

  typedef struct {
    logic         aluen;
    logic         val;
    logic [3:0]   addr;
    logic [2:0]   op;
    logic [W-1:0] din;
    logic [W-1:0] exp_bus;
    logic [8:0]   exp_ir;
    logic         exp_zero;
    logic         exp_carry;
  } vec_t;

  vec_t vecs[$];

  function automatic void add_vec(input logic al, input logic v, input logic [3:0] ad,
                                  input logic [2:0] op, input logic [W-1:0] d,
                                  input logic [W-1:0] eb, input logic z, input logic c);
    vec_t t;
    t.aluen = al; t.val = v; t.addr = ad; t.op = op; t.din = d;
    t.exp_bus = eb; t.exp_ir = 9'h0A3; t.exp_zero = z; t.exp_carry = c;
    vecs.push_back(t);
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Commands are held for two clocks, as the control unit does.
  task automatic apply_cmd(input logic al, input logic v, input logic [3:0] ad,
                           input logic [2:0] op, input logic [W-1:0] d);
    @(negedge clk);
    aluen = al; val = v; addr = ad; opcode = op; din = d;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; din = '0; addr = 4'd0; val = 1'b1; aluen = 1'b0; opcode = OP_MV;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_ir", W'(ir), '0);
    check("rst_bus_q", bus_q, '0);
    check("rst_zero", W'(zero), '0);
    check("rst_carry", W'(carry), '0);

    // Build up state, then reset between edges while an ALU command is active.
    apply_cmd(0, 1, ADDR_DIN, OP_MV, 9'h0A3);
    apply_cmd(0, 0, ADDR_IR,  OP_MV, 9'h0A3);
    apply_cmd(0, 1, ADDR_DIN, OP_MV, 9'h005);
    apply_cmd(0, 0, 4'd3,     OP_MV, 9'h005);
    apply_cmd(0, 0, ADDR_A,   OP_MV, 9'h005);
    check("pre_rst_ir", W'(ir), 9'h0A3);
    check("pre_rst_bus_q", bus_q, 9'h005);
    @(negedge clk);
    aluen = 1'b1; opcode = OP_SUB;
    @(posedge clk);
    #1;
    check("pre_rst_zero", W'(zero), 9'h001);
    #2 reset = 1'b1;
    #1;
    check("async_rst_ir", W'(ir), '0);
    check("async_rst_bus_q", bus_q, '0);
    check("async_rst_zero", W'(zero), '0);
    check("async_rst_carry", W'(carry), '0);
    @(negedge clk);
    reset = 1'b0;
    aluen = 1'b0; val = 1'b1; addr = ADDR_DIN; din = 9'h0A3;
    repeat (2) @(posedge clk);
    #1;
    check("post_rst_fetch_bus", bus_q, 9'h0A3);
    check("post_rst_fetch_ir_old", W'(ir), '0);
    apply_cmd(0, 0, ADDR_IR, OP_MV, 9'h0A3);
    check("post_rst_fetch_ir", W'(ir), 9'h0A3);
    apply_cmd(0, 1, 4'd3, OP_MV, 9'h0A3);
    check("post_rst_r3", bus_q, '0);
    apply_cmd(0, 1, ADDR_A, OP_MV, 9'h0A3);
    check("post_rst_a", bus_q, '0);

    //        aluen val addr     op      din     bus     z  c
    add_vec(0, 1, ADDR_DIN, OP_MV,  9'h0A3, 9'h0A3, 0, 0);
    add_vec(0, 0, ADDR_IR,  OP_MV,  9'h0A3, 9'h0A3, 0, 0);
    add_vec(0, 1, 4'd0,     OP_MV,  9'h0A3, 9'h000, 0, 0);
    add_vec(0, 1, 4'd7,     OP_MV,  9'h0A3, 9'h000, 0, 0);
    add_vec(0, 1, ADDR_DIN, OP_MV,  9'h015, 9'h015, 0, 0);
    add_vec(0, 0, 4'd2,     OP_MV,  9'h015, 9'h015, 0, 0);
    add_vec(0, 1, 4'd13,    OP_MV,  9'h015, 9'h000, 0, 0);
    add_vec(0, 1, 4'd2,     OP_MV,  9'h015, 9'h015, 0, 0);
    add_vec(0, 0, 4'd5,     OP_MV,  9'h015, 9'h015, 0, 0);
    add_vec(0, 1, 4'd0,     OP_MV,  9'h015, 9'h000, 0, 0);
    add_vec(0, 1, 4'd5,     OP_MV,  9'h015, 9'h015, 0, 0);
    add_vec(0, 1, ADDR_DIN, OP_MV,  9'h1FF, 9'h1FF, 0, 0);
    add_vec(0, 0, 4'd1,     OP_MV,  9'h1FF, 9'h1FF, 0, 0);
    add_vec(0, 1, ADDR_DIN, OP_MV,  9'h002, 9'h002, 0, 0);
    add_vec(0, 0, 4'd2,     OP_MV,  9'h002, 9'h002, 0, 0);
    add_vec(0, 1, 4'd1,     OP_MV,  9'h002, 9'h1FF, 0, 0);
    add_vec(0, 0, ADDR_A,   OP_MV,  9'h002, 9'h1FF, 0, 0);
    add_vec(0, 1, 4'd2,     OP_MV,  9'h002, 9'h002, 0, 0);
    add_vec(1, 1, 4'd4,     OP_ADD, 9'h002, 9'h002, 0, 1);
    add_vec(0, 1, ADDR_G,   OP_MV,  9'h002, 9'h001, 0, 1);
    add_vec(0, 0, 4'd1,     OP_MV,  9'h002, 9'h001, 0, 1);
    add_vec(0, 1, 4'd0,     OP_MV,  9'h002, 9'h000, 0, 1);
    add_vec(0, 1, 4'd1,     OP_MV,  9'h002, 9'h001, 0, 1);
    add_vec(1, 1, 4'd4,     OP_MV,  9'h002, 9'h001, 0, 0);
    add_vec(0, 1, 4'd4,     OP_MV,  9'h002, 9'h000, 0, 0);
    add_vec(0, 1, ADDR_DIN, OP_MV,  9'h1AB, 9'h1AB, 0, 0);
    add_vec(0, 0, ADDR_DIN, OP_MV,  9'h1AB, 9'h1AB, 0, 0);
    add_vec(0, 0, 4'd14,    OP_MV,  9'h1AB, 9'h1AB, 0, 0);
    add_vec(0, 1, 4'd0,     OP_MV,  9'h1AB, 9'h000, 0, 0);
    add_vec(0, 1, 4'd1,     OP_MV,  9'h1AB, 9'h001, 0, 0);
    add_vec(0, 1, 4'd2,     OP_MV,  9'h1AB, 9'h002, 0, 0);
    add_vec(0, 1, 4'd3,     OP_MV,  9'h1AB, 9'h000, 0, 0);
    add_vec(0, 1, 4'd4,     OP_MV,  9'h1AB, 9'h000, 0, 0);
    add_vec(0, 1, 4'd5,     OP_MV,  9'h1AB, 9'h015, 0, 0);
    add_vec(0, 1, 4'd6,     OP_MV,  9'h1AB, 9'h000, 0, 0);
    add_vec(0, 1, 4'd7,     OP_MV,  9'h1AB, 9'h000, 0, 0);
    add_vec(0, 1, ADDR_A,   OP_MV,  9'h1AB, 9'h1FF, 0, 0);
    add_vec(0, 1, ADDR_IR,  OP_MV,  9'h1AB, 9'h0A3, 0, 0);
    add_vec(0, 1, 4'd14,    OP_MV,  9'h1AB, 9'h000, 0, 0);
    add_vec(0, 1, ADDR_G,   OP_MV,  9'h1AB, 9'h001, 0, 0);
    add_vec(0, 1, ADDR_DIN, OP_MV,  9'h007, 9'h007, 0, 0);
    add_vec(0, 0, ADDR_A,   OP_MV,  9'h007, 9'h007, 0, 0);
    add_vec(1, 0, 4'd0,     OP_SUB, 9'h007, 9'h007, 1, 0);
    add_vec(0, 1, ADDR_G,   OP_MV,  9'h007, 9'h000, 1, 0);
    add_vec(0, 1, ADDR_DIN, OP_MV,  9'h003, 9'h003, 1, 0);
    add_vec(0, 0, ADDR_A,   OP_MV,  9'h003, 9'h003, 1, 0);
    add_vec(0, 1, ADDR_DIN, OP_MV,  9'h004, 9'h004, 1, 0);
    add_vec(1, 1, 4'd0,     OP_SUB, 9'h004, 9'h004, 0, 1);
    add_vec(0, 1, ADDR_G,   OP_MV,  9'h004, 9'h1FF, 0, 1);
    add_vec(0, 1, ADDR_DIN, OP_MV,  9'h004, 9'h004, 0, 1);
    add_vec(1, 1, 4'd0,     OP_SLT, 9'h004, 9'h004, 0, 0);
    add_vec(0, 1, ADDR_G,   OP_MV,  9'h004, 9'h001, 0, 0);
    add_vec(1, 1, 4'd0,     OP_SLT, 9'h004, 9'h001, 1, 0);
    add_vec(1, 1, 4'd0,     OP_XOR, 9'h004, 9'h001, 0, 0);
    add_vec(1, 1, 4'd0,     OP_AND, 9'h004, 9'h001, 0, 0);
    add_vec(0, 1, ADDR_G,   OP_MV,  9'h004, 9'h001, 0, 0);
    add_vec(1, 1, 4'd0,     OP_OR,  9'h004, 9'h001, 0, 0);
    add_vec(0, 1, ADDR_G,   OP_MV,  9'h004, 9'h003, 0, 0);
    add_vec(0, 1, ADDR_DIN, OP_MV,  9'h004, 9'h004, 0, 0);
    add_vec(1, 1, 4'd0,     OP_XOR, 9'h004, 9'h004, 0, 0);
    add_vec(0, 1, ADDR_G,   OP_MV,  9'h004, 9'h007, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      apply_cmd(vecs[i].aluen, vecs[i].val, vecs[i].addr, vecs[i].op, vecs[i].din);
      check($sformatf("vec%0d_bus_q", i), bus_q, vecs[i].exp_bus);
      check($sformatf("vec%0d_ir", i), W'(ir), W'(vecs[i].exp_ir));
      check($sformatf("vec%0d_zero", i), W'(zero), W'(vecs[i].exp_zero));
      check($sformatf("vec%0d_carry", i), W'(carry), W'(vecs[i].exp_carry));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_datapath.md
Name: bus_datapath

Overview:
- Responder end of the control unit's transfer bus.
- Decodes the per-cycle command {addr, val, aluen, opcode}. Performs the selected register-to-bus or bus-to-register transfer, or an ALU operation.
- Holds R0-R7, the ALU operand register A, the result register G, the instruction register IR, and a registered bus latch.
- Feeds ir back to the control unit, closing the fetch/execute loop.

Parameters:
- DATA_W, 9, width of the bus, registers, din and ALU. Must be >= 9 so the bus can carry an instruction.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- din  in  DATA_W  external data input, source address 8.
- addr  in  4  transfer address from the control unit.
- val  in  1  transfer direction: 1 = selected source drives the bus; 0 = selected destination loads from the bus.
- aluen  in  1  ALU operation enable; overrides val/addr.
- opcode  in  3  ALU function, sampled when aluen=1.
- ir  out  9  instruction register, to the control unit.
- bus_q  out  DATA_W  registered bus latch, for observation.
- zero  out  1  set when the last ALU result was 0.
- carry  out  1  carry/borrow of the last add/sub.

Behaviour:
- Address map:
  - 0-7: R0-R7.
  - 8: din, read only; writes are ignored.
  - 9: A.
  - 10: G.
  - 11: IR; a write loads bus_q[8:0], a read returns IR zero-extended.
  - 12-15: reserved; a read returns 0, a write is ignored.
- Reset (asynchronous, any time, including mid-instruction): R0-R7, A, G, IR, bus_q, zero and carry all become 0 immediately. There is no pending state, so the first command after reset deasserts is decoded normally.
- Read cycle (aluen=0, val=1): at the clock edge, bus_q <= source(addr). One-cycle latency; the source is unchanged.
- Write cycle (aluen=0, val=0): at the clock edge, dest(addr) <= bus_q. bus_q is unchanged.
- ALU cycle (aluen=1): val and addr are ignored, including undriven val. At the clock edge, G <= f(A, bus_q), and zero/carry are updated. bus_q, A and Rn are unchanged.
- ALU functions, with carry meaning:
  - 010: add; carry = carry-out.
  - 011: sub (A - bus_q); carry = 1 on borrow.
  - 100: and; carry = 0.
  - 101: or; carry = 0.
  - 110: xor; carry = 0.
  - 111: unsigned set-less-than, G = (A < bus_q) ? 1 : 0; carry = 0.
  - 000/001: pass, G = bus_q; carry = 0.
  - zero = (new G == 0) for every opcode.
- Arithmetic wraps modulo 2^DATA_W. There is no overflow trap.
- Idempotence: the control unit holds each command for two clocks, and every operation above yields the same result when repeated with unchanged inputs. No edge detection is used.
- Consecutive commands:
  - A write followed by a read of the same register returns the newly written value.
  - A read of G in the cycle after an ALU cycle returns the new result.
- X/Z on val when aluen=0 is a protocol violation; the bench asserts this never happens.
- Sequences supported:
  - fetch: read 8, write 11.
  - load immediate: read 8, write Rx.
  - move: read Ry, write Rx.
  - ALU: read Rx, write 9, read Ry, aluen, read 10, write Rx.

Decomposition:
- Shared package: DATA_W default, address constants (ADDR_DIN=8, ADDR_A=9, ADDR_G=10, ADDR_IR=11), and opcode constants (OP_MV, OP_MVI, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT). The control unit uses the same constants.
- One combinational sub-module, bus_alu, inputs (a, b, op), outputs (result, carry). bus_datapath contains the register file, address decode and bus latch.

Test Plan:
- Reset during an ALU sequence (R3 = 5 loaded, A = 5, aluen pending), reset pulsed asynchronously between clock edges -> all outputs 0 before the next edge; the next fetch works normally.
- Fetch: din = 9'h0A3, commands read 8 then write 11, each held two clocks -> ir = 9'h0A3 and bus_q = 9'h0A3; R0-R7 unchanged.
- Load immediate and move: din = 9'h015, read 8 then write 2; then read 2 then write 5 -> R2 = R5 = 9'h015. A read of addr 13 gives bus_q = 0.
- Add with wrap: R1 = 9'h1FF, R2 = 9'h002, sequence ending in aluen with opcode 010 -> G = 9'h001, carry = 1, zero = 0. R1 = 9'h001 after read 10 / write 1.
- Sub to zero and SLT: A = 9'h007, bus_q = 9'h007, opcode 011 -> G = 0, zero = 1, carry = 0. A = 3, bus_q = 4, opcode 111 -> G = 1, zero = 0.
- Override and ignored writes: aluen = 1 with val = 1, addr = 4 -> bus_q unchanged and R4 unchanged. A write to addr 8 or 14 -> no register changes.
